// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared types and constants for the UART TX scheduler.
// Contents: FSM state encoding, source IDs (also the grant bit positions),
// and the per-source byte counts.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } sched_state_t;

  // Source IDs double as bit positions in the one-hot grant vector.
  localparam int SRC_RF  = 0;
  localparam int SRC_ALU = 1;

  // Bytes sent per item.
  localparam logic [1:0] NBYTES_RF  = 2'd1;
  localparam logic [1:0] NBYTES_ALU = 2'd2;

endpackage

// File: rtl/tx_sched_arbiter.sv
// tx_sched_arbiter: two-request arbiter (RF slot vs ALU slot), one-hot grant.
// Latency: combinational grant; only the round-robin pointer is registered.
// Ports: i_clk/i_rst (pointer only), i_rf_full/i_alu_full requests,
//        i_gnt_en qualifies the grant, o_gnt one-hot {ALU, RF}.
// Macro UART_TX_SCHED_RR_EN: round-robin when defined, else fixed ALU > RF.
module tx_sched_arbiter
  import uart_tx_sched_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rf_full,
  input  logic       i_alu_full,
  input  logic       i_gnt_en,
  output logic [1:0] o_gnt
);

  logic w_pick_alu;

`ifdef UART_TX_SCHED_RR_EN
  // Pointer names the source preferred on a tie; reset prefers RF.
  logic r_prefer_alu;

  assign w_pick_alu = i_alu_full & (~i_rf_full | r_prefer_alu);

  // Advances on every grant, including grants whose frame later times out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prefer_alu <= 1'b0;
    end else if (i_gnt_en && (i_rf_full || i_alu_full)) begin
      r_prefer_alu <= ~w_pick_alu;
    end
  end
`else
  logic w_unused_clk_rst;

  assign w_pick_alu       = i_alu_full;
  assign w_unused_clk_rst = i_clk ^ i_rst;
`endif

  always_comb begin
    o_gnt = 2'b00;
    if (i_gnt_en) begin
      o_gnt[SRC_ALU] = w_pick_alu;
      o_gnt[SRC_RF]  = i_rf_full & ~w_pick_alu;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART TX between an RF byte source and an ALU
//   16-bit source (sent LSB first), pacing each byte off TX_BUSY with an ack timeout.
// Latency: capture -> TX_D_VLD in 2 cycles; next ALU byte 1 cycle after busy falls.
// Backpressure: one slot per source; RF_RDY/ALU_RDY low while the slot is held.
// Ports: RF_RD_DATA/RF_RD_VLD/RF_RDY and ALU_OUT/ALU_OUT_VLD/ALU_RDY inputs,
//        TX_BUSY/TX_P_DATA/TX_D_VLD to the UART, SCHED_BUSY and TIMEOUT_ERR status.
// Macro UART_TX_SCHED_RR_EN (in tx_sched_arbiter): round-robin arbitration.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  output logic                    RF_RDY,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    ALU_RDY,
  input  logic                    TX_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    SCHED_BUSY,
  output logic                    TIMEOUT_ERR
);

  // WAIT_HI starts one cycle after the strobe and the error pulse is
  // registered, so deciding at count ACK_TIMEOUT-2 puts the pulse exactly
  // ACK_TIMEOUT cycles after the strobe.
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 2);

  logic                    r_rf_full;
  logic [DATA_WIDTH-1:0]   r_rf_dat;
  logic                    r_alu_full;
  logic [2*DATA_WIDTH-1:0] r_alu_dat;

  sched_state_t            r_state;
  logic                    r_src_alu;
  logic [1:0]              r_nbytes;
  logic                    r_idx;
  logic [7:0]              r_to_cnt;
  logic [DATA_WIDTH-1:0]   r_tx_dat;
  logic                    r_tx_vld;
  logic                    r_to_err;

  logic [1:0]              w_gnt;
  logic                    w_gnt_en;
  logic                    w_abort;
  logic                    w_frame_done;
  logic                    w_clr_rf;
  logic                    w_clr_alu;
  logic [DATA_WIDTH-1:0]   w_byte;

  assign w_gnt_en     = (r_state == ST_IDLE) & ~TX_BUSY;
  assign w_abort      = (r_state == ST_WAIT_HI) & ~TX_BUSY & (r_to_cnt == TO_LAST);
  assign w_frame_done = (r_state == ST_WAIT_LO) & ~TX_BUSY &
                        (({1'b0, r_idx} + 2'd1) == r_nbytes);
  assign w_clr_rf     = (w_abort | w_frame_done) & ~r_src_alu;
  assign w_clr_alu    = (w_abort | w_frame_done) & r_src_alu;

  tx_sched_arbiter u_arb (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_rf_full  (r_rf_full),
    .i_alu_full (r_alu_full),
    .i_gnt_en   (w_gnt_en),
    .o_gnt      (w_gnt)
  );

  // Byte for the next strobe: in IDLE it is byte 0 of the granted source;
  // elsewhere it only feeds the follow-on strobe, which only ALU frames have.
  always_comb begin
    w_byte = r_rf_dat;
    if (r_state == ST_IDLE) begin
      if (w_gnt[SRC_ALU]) w_byte = r_alu_dat[DATA_WIDTH-1:0];
    end else if (r_src_alu) begin
      w_byte = r_alu_dat[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  // Slots: capture needs an empty slot and clear needs a full one, so the
  // two can never hit the same slot in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rf_full  <= 1'b0;
      r_rf_dat   <= '0;
      r_alu_full <= 1'b0;
      r_alu_dat  <= '0;
    end else begin
      if (RF_RD_VLD && !r_rf_full) begin
        r_rf_full <= 1'b1;
        r_rf_dat  <= RF_RD_DATA;
      end else if (w_clr_rf) begin
        r_rf_full <= 1'b0;
      end
      if (ALU_OUT_VLD && !r_alu_full) begin
        r_alu_full <= 1'b1;
        r_alu_dat  <= ALU_OUT;
      end else if (w_clr_alu) begin
        r_alu_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_src_alu <= 1'b0;
      r_nbytes  <= 2'd0;
      r_idx     <= 1'b0;
      r_to_cnt  <= 8'd0;
      r_tx_dat  <= '0;
      r_tx_vld  <= 1'b0;
      r_to_err  <= 1'b0;
    end else begin
      r_tx_vld <= 1'b0;
      r_to_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Grant is non-zero only with TX idle and a slot full.
          if (w_gnt != 2'b00) begin
            r_src_alu <= w_gnt[SRC_ALU];
            r_nbytes  <= w_gnt[SRC_ALU] ? NBYTES_ALU : NBYTES_RF;
            r_idx     <= 1'b0;
            r_tx_dat  <= w_byte;
            r_tx_vld  <= 1'b1;
            r_state   <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          r_to_cnt <= 8'd0;
          r_state  <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (TX_BUSY) begin
            r_state <= ST_WAIT_LO;
          end else if (w_abort) begin
            r_to_err <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end
        ST_WAIT_LO: begin
          if (!TX_BUSY) begin
            if (w_frame_done) begin
              r_state <= ST_IDLE;
            end else begin
              r_idx    <= 1'b1;
              r_tx_dat <= w_byte;
              r_tx_vld <= 1'b1;
              r_state  <= ST_STROBE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign RF_RDY      = ~r_rf_full;
  assign ALU_RDY     = ~r_alu_full;
  assign TX_P_DATA   = r_tx_dat;
  assign TX_D_VLD    = r_tx_vld;
  assign TIMEOUT_ERR = r_to_err;
  assign SCHED_BUSY  = (r_state != ST_IDLE);

endmodule
